// File: rtl/pc_fetch_unit_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pc_fetch_unit_if : control strobes, memory data and IR/PC status  |
// |                    bundle for pc_fetch_unit                       |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
interface pc_fetch_unit_if;
  // control strobes and data into the fetch unit
  logic        PCEN;
  logic        PCinstruction;
  logic        nextInstruction;
  logic        BranchEN;
  logic        JmpEN;
  logic        JALEN;
  logic [15:0] memData;
  logic [15:0] regTarget;

  // fetch address, IR fields and status out of the fetch unit
  logic [15:0] memAddr;
  logic [3:0]  opCode1;
  logic [3:0]  conditionCode;
  logic [3:0]  opCode2;
  logic [3:0]  shiftAmtIn;
  logic [3:0]  rDest;
  logic [3:0]  rSrc;
  logic [7:0]  imm8;
  logic [15:0] linkAddr;
  logic [15:0] instrPC;
  logic        instrValid;
  logic [31:0] instrCount;

  modport master (
    output PCEN, PCinstruction, nextInstruction, BranchEN, JmpEN, JALEN,
    output memData, regTarget,
    input  memAddr, opCode1, conditionCode, opCode2, shiftAmtIn,
    input  rDest, rSrc, imm8, linkAddr, instrPC, instrValid, instrCount
  );

  modport slave (
    input  PCEN, PCinstruction, nextInstruction, BranchEN, JmpEN, JALEN,
    input  memData, regTarget,
    output memAddr, opCode1, conditionCode, opCode2, shiftAmtIn,
    output rDest, rSrc, imm8, linkAddr, instrPC, instrValid, instrCount
  );
endinterface
`default_nettype wire

// File: rtl/pc_fetch_unit.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pc_fetch_unit : program counter, instruction register and branch |
// |                 / jump / JAL redirect logic                       |
// | Optional retired-fetch counter: define PC_FETCH_INSTR_COUNT_EN    |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module pc_fetch_unit #(
  parameter logic [15:0] PC_RESET = 16'h0000
) (
  input  wire logic          clk,
  input  wire logic          reset,
  pc_fetch_unit_if.slave     bus
);

  logic [15:0] r_pc;
  logic [15:0] r_instr_pc;
  logic [15:0] r_ir;
  logic [15:0] r_link_addr;
  logic        r_prev_fetch;
  logic        r_instr_valid;

  logic        w_pc_update_en;
  logic        w_ir_load;
  logic [15:0] w_branch_target;
  logic [15:0] w_pc_inc;

  assign w_pc_update_en  = bus.PCEN & bus.PCinstruction;
  // Memory returns data one cycle after the address, so IR loads on the second fetch cycle
  assign w_ir_load       = bus.nextInstruction & r_prev_fetch;
  assign w_branch_target = r_instr_pc + {{8{r_ir[7]}}, r_ir[7:0]};
  assign w_pc_inc        = r_pc + 16'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc        <= PC_RESET;
      r_instr_pc  <= PC_RESET;
      r_link_addr <= 16'h0000;
    end else if (w_pc_update_en) begin
      if (bus.nextInstruction) begin
        r_instr_pc <= r_pc;
        r_pc       <= w_pc_inc;
      end else if (bus.JmpEN) begin
        r_pc <= bus.regTarget;
      end else if (bus.JALEN) begin
        // r_pc already points past the JAL, so it is the return address
        r_pc        <= bus.regTarget;
        r_link_addr <= r_pc;
      end else if (bus.BranchEN) begin
        r_pc <= w_branch_target;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ir          <= 16'h0000;
      r_prev_fetch  <= 1'b0;
      r_instr_valid <= 1'b0;
    end else begin
      r_prev_fetch  <= bus.nextInstruction;
      r_instr_valid <= w_ir_load;
      if (w_ir_load) begin
        r_ir <= bus.memData;
      end
    end
  end

`ifdef PC_FETCH_INSTR_COUNT_EN
  logic [31:0] r_instr_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_instr_count <= 32'h0000_0000;
    end else if (w_ir_load) begin
      r_instr_count <= r_instr_count + 32'd1;
    end
  end

  assign bus.instrCount = r_instr_count;
`else
  assign bus.instrCount = 32'h0000_0000;
`endif

  assign bus.memAddr       = r_pc;
  assign bus.instrPC       = r_instr_pc;
  assign bus.linkAddr      = r_link_addr;
  assign bus.instrValid    = r_instr_valid;

  assign bus.opCode1       = r_ir[15:12];
  assign bus.conditionCode = r_ir[11:8];
  assign bus.rDest         = r_ir[11:8];
  assign bus.opCode2       = r_ir[7:4];
  assign bus.shiftAmtIn    = r_ir[3:0];
  assign bus.rSrc          = r_ir[3:0];
  assign bus.imm8          = r_ir[7:0];

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_pc_fetch_unit : directed self-checking bench for pc_fetch_unit |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module tb_pc_fetch_unit;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  pc_fetch_unit_if bus ();

  pc_fetch_unit #(.PC_RESET(16'h0000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] exp_cnt(input int n);
`ifdef PC_FETCH_INSTR_COUNT_EN
    return 32'(n);
`else
    return 32'h0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic nx, input logic pe, input logic pi, input logic br,
                       input logic jp, input logic jl, input logic [15:0] md,
                       input logic [15:0] rt);
    bus.nextInstruction = nx;
    bus.PCEN            = pe;
    bus.PCinstruction   = pi;
    bus.BranchEN        = br;
    bus.JmpEN           = jp;
    bus.JALEN           = jl;
    bus.memData         = md;
    bus.regTarget       = rt;
  endtask

  // one clock: apply inputs, take the edge, settle outputs
  task automatic cyc(input logic nx, input logic pe, input logic pi, input logic br,
                     input logic jp, input logic jl, input logic [15:0] md,
                     input logic [15:0] rt);
    drive(nx, pe, pi, br, jp, jl, md, rt);
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc",      {16'h0, bus.memAddr},  32'h0);
    chk("rst_instrpc", {16'h0, bus.instrPC},  32'h0);
    chk("rst_ir",      {16'h0, bus.opCode1, bus.conditionCode, bus.imm8}, 32'h0);
    chk("rst_link",    {16'h0, bus.linkAddr}, 32'h0);
    chk("rst_valid",   {31'h0, bus.instrValid}, 32'h0);
    chk("rst_count",   bus.instrCount, 32'h0);
    reset = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);

    // Basic two-cycle fetch of 5A13
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h5A13, 16'h0000);
    chk("f1_pc",      {16'h0, bus.memAddr}, 32'h0001);
    chk("f1_instrpc", {16'h0, bus.instrPC}, 32'h0000);
    chk("f1_noload",  {28'h0, bus.opCode1}, 32'h0);
    chk("f1_valid",   {31'h0, bus.instrValid}, 32'h0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h5A13, 16'h0000);
    chk("f2_pc",      {16'h0, bus.memAddr}, 32'h0001);
    chk("f2_op1",     {28'h0, bus.opCode1}, 32'h5);
    chk("f2_rdest",   {28'h0, bus.rDest}, 32'hA);
    chk("f2_cc",      {28'h0, bus.conditionCode}, 32'hA);
    chk("f2_op2",     {28'h0, bus.opCode2}, 32'h1);
    chk("f2_rsrc",    {28'h0, bus.rSrc}, 32'h3);
    chk("f2_shamt",   {28'h0, bus.shiftAmtIn}, 32'h3);
    chk("f2_imm8",    {24'h0, bus.imm8}, 32'h13);
    chk("f2_valid",   {31'h0, bus.instrValid}, 32'h1);
    chk("f2_count",   bus.instrCount, exp_cnt(1));
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    chk("f3_valid",   {31'h0, bus.instrValid}, 32'h0);

    // Strobes ignored without both PCEN and PCinstruction
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'hBEEF);
    chk("hold_pci_pc", {16'h0, bus.memAddr}, 32'h0001);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 16'hBEEF);
    chk("hold_pen_pc",   {16'h0, bus.memAddr}, 32'h0001);
    chk("hold_pen_link", {16'h0, bus.linkAddr}, 32'h0000);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    chk("hold_adv_pc",   {16'h0, bus.memAddr}, 32'h0001);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);

    // Backward branch: instrPC 0010 + sext(FC) = 000C
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0010);
    chk("jmp10_pc", {16'h0, bus.memAddr}, 32'h0010);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'hC2FC, 16'h0000);
    chk("adv11_pc",      {16'h0, bus.memAddr}, 32'h0011);
    chk("adv11_instrpc", {16'h0, bus.instrPC}, 32'h0010);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'hC2FC, 16'h0000);
    chk("c2fc_imm8",  {24'h0, bus.imm8}, 32'hFC);
    chk("c2fc_count", bus.instrCount, exp_cnt(2));
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
    chk("br_back_pc",  {16'h0, bus.memAddr}, 32'h000C);
    chk("br_valid",    {31'h0, bus.instrValid}, 32'h0);

    // Branch not taken holds pc
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0010);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    chk("br_nt_pc",   {16'h0, bus.memAddr}, 32'h0011);
    chk("br_nt_imm8", {24'h0, bus.imm8}, 32'hFC);

    // JAL and jump priority over branch
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0020);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    chk("adv21_pc", {16'h0, bus.memAddr}, 32'h0021);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0300);
    chk("jal_pc",       {16'h0, bus.memAddr}, 32'h0300);
    chk("jal_link",     {16'h0, bus.linkAddr}, 32'h0021);
    chk("jal_instrpc",  {16'h0, bus.instrPC}, 32'h0020);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h1234);
    chk("jmpbr_pc",   {16'h0, bus.memAddr}, 32'h1234);
    chk("jmpbr_link", {16'h0, bus.linkAddr}, 32'h0021);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0000, 16'h0456);
    chk("jmpjal_pc",   {16'h0, bus.memAddr}, 32'h0456);
    chk("jmpjal_link", {16'h0, bus.linkAddr}, 32'h0021);

    // PC wrap and forward branch across 0000
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 16'hFFFF);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    chk("wrap_pc",      {16'h0, bus.memAddr}, 32'h0000);
    chk("wrap_instrpc", {16'h0, bus.instrPC}, 32'hFFFF);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 16'hFFF0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0020, 16'h0000);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0020, 16'h0000);
    chk("fff0_instrpc", {16'h0, bus.instrPC}, 32'hFFF0);
    chk("fff0_imm8",    {24'h0, bus.imm8}, 32'h20);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
    chk("br_fwd_pc", {16'h0, bus.memAddr}, 32'h0010);

    // Back-to-back fetches reload IR every cycle from the second
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h1111, 16'h0000);
    chk("bb1_ir",    {16'h0, bus.opCode1, bus.conditionCode, bus.imm8}, 32'h0020);
    chk("bb1_valid", {31'h0, bus.instrValid}, 32'h0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h2222, 16'h0000);
    chk("bb2_ir",    {16'h0, bus.opCode1, bus.conditionCode, bus.imm8}, 32'h2222);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h3333, 16'h0000);
    chk("bb3_ir",    {16'h0, bus.opCode1, bus.conditionCode, bus.imm8}, 32'h3333);
    chk("bb3_valid", {31'h0, bus.instrValid}, 32'h1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h4444, 16'h0000);
    chk("bb4_count", bus.instrCount, exp_cnt(6));
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    chk("bb5_ir",    {16'h0, bus.opCode1, bus.conditionCode, bus.imm8}, 32'h4444);
    chk("bb5_valid", {31'h0, bus.instrValid}, 32'h0);

    // Isolated fetch cycle does not load
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h7777, 16'h0000);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    chk("iso_ir",    {16'h0, bus.opCode1, bus.conditionCode, bus.imm8}, 32'h4444);
    chk("iso_valid", {31'h0, bus.instrValid}, 32'h0);
    chk("iso_count", bus.instrCount, exp_cnt(6));

    // Reset asserted between the two fetch cycles discards the fetch
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h8888, 16'h0000);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h9999, 16'h0000);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_pc",    {16'h0, bus.memAddr}, 32'h0000);
    chk("arst_ir",    {16'h0, bus.opCode1, bus.conditionCode, bus.imm8}, 32'h0);
    chk("arst_count", bus.instrCount, 32'h0);
    @(posedge clk);
    #1;
    chk("rstmid_ir",    {16'h0, bus.opCode1, bus.conditionCode, bus.imm8}, 32'h0);
    chk("rstmid_valid", {31'h0, bus.instrValid}, 32'h0);
    reset = 1'b1;
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'hAAAA, 16'h0000);
    chk("post1_ir",    {16'h0, bus.opCode1, bus.conditionCode, bus.imm8}, 32'h0);
    chk("post1_valid", {31'h0, bus.instrValid}, 32'h0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'hBBBB, 16'h0000);
    chk("post2_ir",    {16'h0, bus.opCode1, bus.conditionCode, bus.imm8}, 32'hBBBB);
    chk("post2_valid", {31'h0, bus.instrValid}, 32'h1);
    chk("post2_count", bus.instrCount, exp_cnt(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
